// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random-range generator.
package lfsr_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    // Maximal-length Galois masks for the right-shifting step rule
    localparam logic [7:0]  TAPS8  = 8'hB8;
    localparam logic [15:0] TAPS16 = 16'hB400;
    localparam logic [31:0] TAPS32 = 32'hA300_0000;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_rand_range_if.sv
// Request/result handshake between the game controller and the range generator.
interface lfsr_rand_range_if #(
    parameter int OUT_W = 5
);
    logic             req;
    logic             ready;
    logic             valid;
    logic             busy;
    logic [OUT_W-1:0] num;

    modport master (output req, ready, input valid, num, busy);
    modport slave  (input req, ready, output valid, num, busy);
endinterface

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with reseed; a zero seed is swapped for SEED so it never locks up.
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] step;

    assign step = (state >> 1) ^ (state[0] ? TAPS : '0);

    always_ff @(posedge clk) begin
        if (rst)
            state <= SEED;
        else if (load)
            state <= (seed_in == '0) ? SEED : seed_in;
        else
            state <= step;
    end

endmodule

// File: rtl/lfsr_rand_range.sv
// Uniform 0..RANGE-1 source: LFSR candidates filtered by a request/valid FSM.
// LFSR_RAND_REJECT_EN enables rejection sampling with MAX_TRIES; otherwise a single fold.
module lfsr_rand_range
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = TAPS16,
    parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED,
    parameter int               OUT_W     = 5,
    parameter int               RANGE     = 20,
    parameter int               MAX_TRIES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [WIDTH-1:0]        seed_in,
    lfsr_rand_range_if.slave        rif
);

    localparam logic [OUT_W:0] RANGE_W = (OUT_W+1)'(RANGE);

    logic [WIDTH-1:0] lfsr;
    logic [OUT_W-1:0] cand, folded;
    logic             in_range;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] num_q, num_d;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .seed_in (seed_in),
        .state   (lfsr)
    );

    // Candidate comes from the current register, so a same-cycle load only affects later draws
    assign cand     = lfsr[OUT_W-1:0];
    assign in_range = {1'b0, cand} < RANGE_W;
    // RANGE > 2^(OUT_W-1) keeps cand - RANGE inside 0..RANGE-1
    assign folded   = cand - RANGE_W[OUT_W-1:0];

    if (OUT_W < WIDTH) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^lfsr[WIDTH-1:OUT_W];
    end

`ifdef LFSR_RAND_REJECT_EN
    localparam int RW = $clog2(MAX_TRIES) + 1;
    logic [RW-1:0] rej_q, rej_d;
    logic          last_try;

    assign last_try = (rej_q == RW'(MAX_TRIES - 1));
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        num_d   = num_q;
`ifdef LFSR_RAND_REJECT_EN
        rej_d   = rej_q;
`endif
        case (state_q)
            IDLE: begin
                if (rif.req) begin
                    state_d = DRAW;
`ifdef LFSR_RAND_REJECT_EN
                    rej_d   = '0;
`endif
                end
            end
            DRAW: begin
`ifdef LFSR_RAND_REJECT_EN
                if (in_range) begin
                    num_d   = cand;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (last_try) begin
                    num_d   = folded;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    rej_d   = rej_q + RW'(1);
                end
`else
                num_d   = in_range ? cand : folded;
                valid_d = 1'b1;
                state_d = HOLD;
`endif
            end
            HOLD: begin
                if (rif.ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            num_q   <= '0;
`ifdef LFSR_RAND_REJECT_EN
            rej_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            num_q   <= num_d;
`ifdef LFSR_RAND_REJECT_EN
            rej_q   <= rej_d;
`endif
        end
    end

    assign rif.valid = valid_q;
    assign rif.num   = num_q;
    assign rif.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Directed bench: default DUT, a MAX_TRIES=2 DUT and an exact-range (RANGE=32) DUT share stimulus.
module tb_lfsr_rand_range;

    logic        clk = 1'b0;
    logic        rst, load, req, ready;
    logic [15:0] seed_in;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    lfsr_rand_range_if #(.OUT_W(5)) if0 ();
    lfsr_rand_range_if #(.OUT_W(5)) if1 ();
    lfsr_rand_range_if #(.OUT_W(5)) if2 ();

    assign if0.req = req;  assign if0.ready = ready;
    assign if1.req = req;  assign if1.ready = ready;
    assign if2.req = req;  assign if2.ready = ready;

    lfsr_rand_range u_def (
        .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .rif(if0));
    lfsr_rand_range #(.MAX_TRIES(2)) u_mt2 (
        .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .rif(if1));
    lfsr_rand_range #(.RANGE(32)) u_r32 (
        .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .rif(if2));

    logic       valid_o [3];
    logic       busy_o  [3];
    logic [4:0] num_o   [3];

    assign valid_o[0] = if0.valid;  assign busy_o[0] = if0.busy;  assign num_o[0] = if0.num;
    assign valid_o[1] = if1.valid;  assign busy_o[1] = if1.busy;  assign num_o[1] = if1.num;
    assign valid_o[2] = if2.valid;  assign busy_o[2] = if2.busy;  assign num_o[2] = if2.num;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle offset (from the load cycle) at which valid rises, and the value, for seed 0x007C
    int         vcyc [3];
    logic [4:0] vnum [3];

    initial begin
`ifdef LFSR_RAND_REJECT_EN
        vcyc[0] = 5;  vnum[0] = 5'd15;
        vcyc[1] = 4;  vnum[1] = 5'd11;
`else
        vcyc[0] = 3;  vnum[0] = 5'd10;
        vcyc[1] = 3;  vnum[1] = 5'd10;
`endif
        vcyc[2] = 3;  vnum[2] = 5'd30;

        rst = 1'b1; load = 1'b0; seed_in = '0; req = 1'b0; ready = 1'b0;
        tick();
        tick();

        // Scenario 1: first request out of reset draws from 0xE270 -> 16
        rst = 1'b0; req = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid%0d", d), valid_o[d], 1'b0);
            chk($sformatf("rst_num%0d", d),   num_o[d],   5'd0);
            chk($sformatf("rst_busy%0d", d),  busy_o[d],  1'b0);
        end
        tick();
        req = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("s1_c1_busy%0d", d),  busy_o[d],  1'b1);
            chk($sformatf("s1_c1_valid%0d", d), valid_o[d], 1'b0);
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("s1_c2_valid%0d", d), valid_o[d], 1'b1);
            chk($sformatf("s1_c2_num%0d", d),   num_o[d],   5'd16);
            chk($sformatf("s1_c2_busy%0d", d),  busy_o[d],  1'b1);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("s1_done_valid%0d", d), valid_o[d], 1'b0);
            chk($sformatf("s1_done_busy%0d", d),  busy_o[d],  1'b0);
        end

        // Scenario 2: seed 0x007C gives candidates 30, 31, 15
        load = 1'b1; seed_in = 16'h007C;
        tick();
        load = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        for (int off = 2; off <= 5; off++) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("s2_c%0d_valid%0d", off, d), valid_o[d], (off >= vcyc[d]) ? 1'b1 : 1'b0);
                if (off >= vcyc[d])
                    chk($sformatf("s2_c%0d_num%0d", off, d), num_o[d], vnum[d]);
            end
            if (off < 5) tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int d = 0; d < 3; d++)
            chk($sformatf("s2_done_valid%0d", d), valid_o[d], 1'b0);

        // Scenario 3: zero seed substitutes 0xACE1, so the draw repeats scenario 1
        load = 1'b1; seed_in = 16'h0000;
        tick();
        load = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("s3_valid%0d", d), valid_o[d], 1'b1);
            chk($sformatf("s3_num%0d", d),   num_o[d],   5'd16);
        end

        // Scenario 4: stall with req toggling; result must hold
        for (int i = 0; i < 10; i++) begin
            req = i[0];
            tick();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("hold%0d_valid%0d", i, d), valid_o[d], 1'b1);
                chk($sformatf("hold%0d_num%0d", i, d),   num_o[d],   5'd16);
                chk($sformatf("hold%0d_busy%0d", i, d),  busy_o[d],  1'b1);
            end
        end
        ready = 1'b1; req = 1'b1;
        tick();
        ready = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("hs_valid%0d", d), valid_o[d], 1'b0);
            chk($sformatf("hs_busy%0d", d),  busy_o[d],  1'b0);
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("b2b_busy%0d", d),  busy_o[d],  1'b1);
            chk($sformatf("b2b_valid%0d", d), valid_o[d], 1'b0);
        end

        // Reset during DRAW aborts the request
        rst = 1'b1; req = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("abort_valid%0d", d), valid_o[d], 1'b0);
            chk($sformatf("abort_num%0d", d),   num_o[d],   5'd0);
            chk($sformatf("abort_busy%0d", d),  busy_o[d],  1'b0);
        end
        rst = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("post_valid%0d", d), valid_o[d], 1'b0);
            chk($sformatf("post_busy%0d", d),  busy_o[d],  1'b0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_range.md
# lfsr_rand_range

Parametrised pseudo-random number source that returns a uniform value in 0..RANGE-1 on request. It replaces the fixed five-bit, bank-of-LFSRs generator. It sits between the game controller and the food-placement logic. A single free-running Galois LFSR of configurable width feeds a small request/valid FSM that rejects out-of-range draws, so food coordinates fall inside the playfield without modulo bias.

## Interface
Parameters:
- WIDTH, 16: LFSR register width.
- TAPS, 16'hB400: Galois feedback mask, WIDTH bits wide.
- SEED, 16'hACE1: reset state and zero-seed substitute. Must be nonzero.
- OUT_W, 5: output width. Must satisfy OUT_W <= WIDTH.
- RANGE, 20: exclusive upper bound. Must satisfy 2^(OUT_W-1) < RANGE <= 2^OUT_W.
- MAX_TRIES, 4: draws per request before forced fold. Must be >= 1.

Ports:
- clk, in, 1: the only clock.
- rst, in, 1: synchronous, active-high reset.
- load, in, 1: reseed the LFSR from seed_in.
- seed_in, in, WIDTH: new seed value.
- req, in, 1: request a number. Sampled in IDLE only.
- ready, in, 1: consumer accepts num.
- valid, out, 1: num holds a result.
- num, out, OUT_W: result, always < RANGE.
- busy, out, 1: high in DRAW and HOLD.

## Operation
- LFSR stepping: the LFSR steps every cycle regardless of FSM state.
- Step rule: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- Reseed: when load is high, the LFSR takes seed_in instead of stepping. If seed_in is 0, it takes SEED instead, so lock-up is impossible. load does not affect the FSM.
- Candidate: cand = lfsr[OUT_W-1:0], the current register value.
- IDLE: if req is high, go to DRAW and clear rej_cnt.
- DRAW, accept: if cand < RANGE, num <= cand, valid <= 1, go to HOLD.
- DRAW, fold: if cand >= RANGE and rej_cnt == MAX_TRIES-1, num <= cand - RANGE, valid <= 1, go to HOLD. The RANGE bound guarantees the folded value is < RANGE.
- DRAW, reject: otherwise rej_cnt++ and stay in DRAW. The next cycle samples the next LFSR state.
- rej_cnt width: $clog2(MAX_TRIES)+1.
- HOLD: num and valid stay stable while ready is low. req is ignored. On ready high, clear valid and go to IDLE.
- Back-to-back requests: a new req is accepted the cycle after the handshake completes.
- Exact range: if RANGE == 2^OUT_W, rejection never occurs.

## Timing
- Reset values: LFSR = SEED, state = IDLE, valid = 0, num = 0, busy = 0, rej_cnt = 0.
- Reset mid-operation aborts any draw. No valid is produced for that request.
- Latency: req sampled at edge k gives valid high after edge k+2 minimum. Worst case is after edge k+1+MAX_TRIES.
- busy is high from the cycle after req is sampled until the handshake edge.
- Simultaneous load and DRAW: cand is taken from the pre-load register value. The reseed takes effect the next cycle.
- valid is registered. num changes only on the edge where valid rises.

## Configuration
- LFSR_RAND_REJECT_EN defined: rejection sampling with MAX_TRIES, as described under Operation.
- LFSR_RAND_REJECT_EN undefined: DRAW always completes in one cycle with num = (cand >= RANGE) ? cand - RANGE : cand. rej_cnt is removed and MAX_TRIES is unused. Latency is fixed at 2 cycles.

## Structure
- Package lfsr_pkg holds:
  - the state enum {IDLE, DRAW, HOLD};
  - default TAPS constants for widths 8, 16 and 32;
  - the DEFAULT_SEED constant.
- Sub-module lfsr_core (clk, rst, load, seed_in, state) holds the register, the step rule and the zero-seed substitution. lfsr_rand_range contains the FSM and the range logic.

## Test plan
All scenarios use default parameters with LFSR_RAND_REJECT_EN defined unless stated.

- Reset, then req=1 in cycle 0: DRAW samples cand from 0xE270, which is 16. Expect valid in cycle 2, num=16, busy high in cycles 1–2.
- load seed_in=0x007C at cycle c, req at c+1: cands 30 (reject), 31 (reject), then 15 from 0xB40F (accept). Expect valid at c+5, num=15.
- Same stimulus with MAX_TRIES=2: expect fold, valid at c+4, num=11.
- Same stimulus with LFSR_RAND_REJECT_EN undefined: expect valid at c+3, num=10.
- load seed_in=0: LFSR becomes 0xACE1. A following req behaves exactly like the first scenario.
- Hold ready=0 for 10 cycles with req pulsing: num and valid stay stable and no second request is accepted. Assert ready and expect valid to clear the next cycle. Apply rst during DRAW and expect all outputs at reset values the next cycle.
